// File: rtl/beat_pkg.sv
// beat_pkg: beat states, one-hot beat masks and counter width shared by the beat sequencer.
package beat_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, W1 = 2'b01, W2 = 2'b10, W3 = 2'b11} beat_state_t;
    localparam int CNT_W_DEF = 16;
    localparam logic [2:0] W1_HOT = 3'b001;
    localparam logic [2:0] W2_HOT = 3'b010;
    localparam logic [2:0] W3_HOT = 3'b100;
    function automatic logic [2:0] beat_hot(input beat_state_t s);
        return s == W1 ? W1_HOT : s == W2 ? W2_HOT : s == W3 ? W3_HOT : 3'b000;
    endfunction
endpackage

// File: rtl/qd_sync_edge.sv
// qd_sync_edge: multi-flop synchronizer for an asynchronous panel button plus a one-cycle rising-edge pulse.
module qd_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], btn};
            prev <= sync[STAGES-1];
        end
    assign pulse = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: w1/w2/w3 machine-cycle generator obeying short/long/stop, started by qd.
// Define BEAT_PROTO_CHECK_EN to enable the sticky seq_err protocol checker.
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             seq_err
);
    beat_state_t state, nxt;
    logic [2:0] beats;
    logic start, halt, fin, stop_pend;

    qd_sync_edge #(.STAGES(SYNC_STAGES)) u_qd (.clk(t3), .rst_n(clr), .btn(qd), .pulse(start));

    assign halt = stop | stop_pend | step_mode;
    assign {w3, w2, w1} = beats;

    always_comb begin
        fin = 1'b0;
        nxt = IDLE;
        case (state)
            IDLE: nxt = start ? W1 : IDLE;
            W1: begin
                fin = short;
                nxt = short ? (halt ? IDLE : W1) : W2;
            end
            W2: begin
                fin = !long;
                nxt = long ? W3 : (halt ? IDLE : W1);
            end
            W3: begin
                fin = 1'b1;
                nxt = halt ? IDLE : W1;
            end
            default: nxt = IDLE;
        endcase
    end

    // a pending stop only needs to survive until the cycle ends, i.e. until IDLE or W1 is entered
    always_ff @(posedge t3 or negedge clr)
        if (!clr) begin
            state      <= IDLE;
            beats      <= 3'b000;
            running    <= 1'b0;
            instr_done <= 1'b0;
            cycle_cnt  <= '0;
            stop_pend  <= 1'b0;
        end else begin
            state      <= nxt;
            beats      <= beat_hot(nxt);
            running    <= nxt != IDLE;
            instr_done <= fin;
            cycle_cnt  <= cycle_cnt + CNT_W'(fin);
            stop_pend  <= (nxt == IDLE || nxt == W1) ? 1'b0 : stop_pend | (stop && state != IDLE);
        end

`ifdef BEAT_PROTO_CHECK_EN
    logic illegal;
    assign illegal = !(state inside {IDLE, W1, W2, W3});
    always_ff @(posedge t3 or negedge clr)
        if (!clr) seq_err <= 1'b0;
        else if ((state == W1 && short && long) || illegal) seq_err <= 1'b1;
`else
    assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed and randomized checks of beat_sequencer against a cycle-level behavioural model.
module tb_beat_sequencer;
    localparam int S = 2;
    localparam int CW = 16;
`ifdef BEAT_PROTO_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic t3 = 1'b0, clr = 1'b1, qd = 1'b0, step_mode = 1'b0, short = 1'b0, long = 1'b0, stop = 1'b0;
    logic w1, w2, w3, running, instr_done, seq_err;
    logic [CW-1:0] cycle_cnt;
    int tests = 0, fails = 0;

    int mb = 0;
    bit mpend = 1'b0, mdone = 1'b0, merr = 1'b0;
    int unsigned mcnt = 0;
    bit qh[$];

    beat_sequencer #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode), .short(short), .long(long), .stop(stop),
        .w1(w1), .w2(w2), .w3(w3), .running(running), .instr_done(instr_done),
        .cycle_cnt(cycle_cnt), .seq_err(seq_err)
    );

    always #5 t3 = ~t3;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge t3);
        #2;
    endtask

    task automatic press();
        qd = 1'b1;
        step(2);
        qd = 1'b0;
        step(1);
    endtask

    // model: mb is the current beat number (0 = idle); start seen S edges after qd rises
    always @(posedge t3 or negedge clr) begin : model
        bit st, fin;
        int nb;
        if (!clr) begin
            mb = 0; mpend = 0; mdone = 0; mcnt = 0; merr = 0;
            qh.delete();
            repeat (S + 1) qh.push_back(1'b0);
        end else begin
            qh.push_back(qd);
            st = qh[1] && !qh[0];
            void'(qh.pop_front());
            fin = (mb == 1 && short) || (mb == 2 && !long) || mb == 3;
            if (ERR_EN && mb == 1 && short && long) merr = 1;
            if (mb == 0) nb = st ? 1 : 0;
            else if (fin) nb = (stop || mpend || step_mode) ? 0 : 1;
            else nb = mb + 1;
            if (mb != 0 && stop) mpend = 1;
            if (nb <= 1) mpend = 0;
            mdone = fin;
            mcnt = (mcnt + fin) % (2 ** CW);
            mb = nb;
        end
    end

    always @(negedge t3) begin
        chk("outputs", {w1, w2, w3, running, instr_done, seq_err},
            {mb == 1, mb == 2, mb == 3, mb != 0, mdone, merr});
        chk("cycle_cnt", cycle_cnt, mcnt);
    end

    initial begin
        #1 clr = 1'b0;
        #11;
        chk("rst_outputs", {w1, w2, w3, running, instr_done, seq_err}, 0);
        chk("rst_cnt", cycle_cnt, 0);
        @(posedge t3);
        #2 clr = 1'b1;
        qd = 1'b1;
        step(2);
        chk("latency_2_edges", w1, 0);
        step(1);
        chk("latency_3_edges", w1, 1);
        step(2);
        qd = 1'b0;
        step(4);
        chk("free_run_cnt", cycle_cnt, 3);
        chk("free_run_done", instr_done, 1);
        chk("model_cnt", mcnt, 3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        chk("stop_idle", running, 0);
        chk("stop_done", instr_done, 1);
        chk("stop_cnt", cycle_cnt, 4);
        step(1);
        chk("stop_done_once", instr_done, 0);
        press();
        chk("restart_w1", w1, 1);
        long = 1'b1;
        step(1);
        long = 1'b0;
        step(1);
        chk("long_in_w1_ignored", {w1, cycle_cnt}, {1'b1, 16'd5});
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        long = 1'b1;
        step(1);
        chk("long_w3", w3, 1);
        long = 1'b0;
        step(1);
        chk("stop_after_w3", {running, instr_done, cycle_cnt}, {1'b0, 1'b1, 16'd6});
        step(2);
        chk("stays_idle", running, 0);
        step_mode = 1'b1;
        repeat (3) begin
            press();
            step(2);
            chk("step_idle", running, 0);
        end
        chk("step_cnt", cycle_cnt, 9);
        press();
        qd = 1'b1;
        long = 1'b1;
        step(1);
        qd = 1'b0;
        step(1);
        long = 1'b0;
        step(1);
        step(3);
        chk("midcycle_qd_ignored", {running, cycle_cnt}, {1'b0, 16'd10});
        step_mode = 1'b0;
        press();
        short = 1'b1;
        step(5);
        chk("short_run", {w1, instr_done, cycle_cnt}, {1'b1, 1'b1, 16'd15});
        step(65535 - int'(mcnt));
        chk("cnt_all_ones", cycle_cnt, 16'hFFFF);
        step(1);
        chk("cnt_wrap", {w1, cycle_cnt}, {1'b1, 16'd0});
        short = 1'b0;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        chk("post_wrap_idle", {running, cycle_cnt}, {1'b0, 16'd1});
        press();
        short = 1'b1;
        long = 1'b1;
        step(1);
        chk("short_wins", {w1, seq_err}, {1'b1, ERR_EN});
        short = 1'b0;
        long = 1'b0;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);
        chk("seq_err_held", {running, seq_err}, {1'b0, ERR_EN});
        press();
        step(1);
        chk("in_w2", w2, 1);
        clr = 1'b0;
        #1;
        chk("async_clr", {w1, w2, w3, running, instr_done, seq_err, cycle_cnt}, 0);
        #1 clr = 1'b1;
        step(2);
        chk("after_clr_idle", running, 0);
        repeat (4000) begin
            short = ($urandom % 3) == 0;
            long = ($urandom % 2) == 0;
            stop = ($urandom % 10) == 0;
            if ($urandom % 50 == 0) step_mode = ~step_mode;
            if ($urandom % 6 == 0) qd = ~qd;
            if ($urandom % 400 == 0) clr = 1'b0;
            step(1);
            clr = 1'b1;
        end
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
